// File: rtl/channel_fifo_pkg.sv
// channel_fifo_pkg: shared helpers for the channel_fifo slice.
// Contents:
//   is_pow2 - true when a positive integer is an exact power of two,
//             used by the elaboration-time parameter check.
package channel_fifo_pkg;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/channel_fifo_if.sv
// channel_fifo_if: valid/ack Channel carrying an N-bit word.
//
// Handshake: a word moves on a posedge where v & a is 1. The producer
// (master) drives v and d and holds both stable until it samples a high.
// The consumer (slave) drives a and may derive it combinationally from v.
//
// Signals:
//   v - producer has a word on d
//   a - consumer accepts the word this cycle
//   d - N-bit data word
interface channel_fifo_if #(
  parameter int N = 8
);
  logic         v;
  logic         a;
  logic [N-1:0] d;

  modport master (output v, output d, input a);
  modport slave  (input v, input d, output a);
endinterface

// File: rtl/channel_fifo_mem.sv
// channel_fifo_mem: Depth x N register file backing the FIFO.
// Ports:
//   clk   - clock; writes land on posedge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (asynchronous read)
//   rdata - word stored at raddr
// Storage is deliberately not reset; the FIFO pointers define what is valid.
module channel_fifo_mem #(
  parameter int N     = 8,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [N-1:0]             wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [N-1:0]             rdata
);

  logic [N-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/channel_fifo.sv
// channel_fifo: parameterized FIFO with a valid/ack Channel on each side.
// Absorbs producer bursts so a stalled consumer does not immediately stall
// its source. One push and one pop per cycle; in.a depends only on
// registered state, so there is no combinational path from out.a to in.a.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; clears pointers and count
//   in    - input Channel (this block is the consumer, drives in.a)
//   out   - output Channel (this block is the producer, drives out.v/out.d)
//   count - number of occupied entries (registered)
//   full  - count == Depth
//   empty - count == 0
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter int N     = -1,
  parameter int Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  channel_fifo_if.slave              in,
  channel_fifo_if.master             out,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth+1);

  if (!is_pow2(Depth) || Depth < 2) begin : g_bad_depth
    $error("channel_fifo: Depth must be a power of 2 and at least 2");
  end
  if (N < 1) begin : g_bad_width
    $error("channel_fifo: N must be at least 1");
  end

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count_q;
  logic            push;
  logic            pop;

  assign count = count_q;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  // Both handshake outputs are forced low during reset so nothing can
  // transfer on a reset edge.
  assign in.a  = ~full & ~reset;
  assign out.v = ~empty & ~reset;

  assign push = in.v & in.a;
  assign pop  = out.v & out.a;

  // Pointers wrap modulo Depth by natural overflow (Depth is a power of 2).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  channel_fifo_mem #(
    .N     (N),
    .Depth (Depth)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in.d),
    .raddr (rd_ptr),
    .rdata (out.d)
  );

endmodule

// File: tb/tb_channel_fifo.sv
// tb_channel_fifo: self-checking bench for channel_fifo (N=8, Depth=4).
// A queue holds the words the FIFO must contain; every cycle the DUT
// outputs are compared with values derived from that queue.
module tb_channel_fifo;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         drv_rst;
  logic         drv_v;
  logic         drv_a;
  logic [N-1:0] drv_d;

  channel_fifo_if #(.N(N)) in_bus ();
  channel_fifo_if #(.N(N)) out_bus ();

  assign in_bus.v  = drv_v;
  assign in_bus.d  = drv_d;
  assign out_bus.a = drv_a;

  logic [2:0] count;
  logic       full;
  logic       empty;

  channel_fifo #(
    .N     (N),
    .Depth (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (drv_rst),
    .in    (in_bus),
    .out   (out_bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // scoreboard
  logic [N-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit last_push;
  int pop_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven (at negedge). Compare the
  // outputs with the queue, then apply the transfer rules at the posedge.
  task automatic step();
    bit exp_in_a;
    bit exp_out_v;
    bit will_push;
    bit will_pop;
    #2;
    exp_in_a  = !drv_rst && (exp_q.size() < DEPTH);
    exp_out_v = !drv_rst && (exp_q.size() > 0);
    chk("in_a",  in_bus.a,  exp_in_a);
    chk("out_v", out_bus.v, exp_out_v);
    chk("count", count, exp_q.size());
    chk("full",  full,  exp_q.size() == DEPTH);
    chk("empty", empty, exp_q.size() == 0);
    if (exp_out_v) chk("out_d", out_bus.d, exp_q[0]);
    will_push = drv_v && exp_in_a;
    will_pop  = drv_a && exp_out_v;
    @(posedge clk);
    if (drv_rst) begin
      exp_q.delete();
    end else begin
      if (will_pop) begin
        void'(exp_q.pop_front());
        pop_total++;
      end
      if (will_push) exp_q.push_back(drv_d);
    end
    last_push = will_push;
    @(negedge clk);
  endtask

  initial begin
    drv_rst = 1'b1;
    drv_v   = 1'b0;
    drv_a   = 1'b0;
    drv_d   = '0;
    pop_total = 0;
    @(posedge clk);
    @(negedge clk);

    // reset held for two cycles, then idle
    step();
    step();
    drv_rst = 1'b0;
    step();
    step();
    #1;
    chk("idle_empty", empty, 1);
    chk("idle_full",  full,  0);
    chk("idle_count", count, 0);
    chk("idle_out_v", out_bus.v, 0);
    chk("idle_in_a",  in_bus.a,  1);

    // fill with the consumer stalled
    drv_a = 1'b0;
    drv_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_d = N'((i + 1) * 8'h11);
      step();
      #1;
      chk("fill_count", count, i + 1);
    end
    chk("fill_full", full, 1);
    drv_d = 8'h55;
    step();
    #1;
    chk("pend_in_a",  in_bus.a, 0);
    chk("pend_count", count, 4);
    drv_a = 1'b1;
    chk("pop_first_d", out_bus.d, 8'h11);
    step();
    drv_a = 1'b0;
    #1;
    chk("after_pop_in_a", in_bus.a, 1);
    step();
    #1;
    chk("refill_count", count, 4);
    chk("refill_push55", last_push, 1);
    drv_v = 1'b0;
    drv_a = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drained", empty, 1);

    // streaming 0..99 at one word per cycle
    pop_total = 0;
    drv_v = 1'b1;
    drv_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drv_d = N'(i);
      step();
    end
    #1;
    chk("stream_count", count, 1);
    chk("stream_pops", pop_total, 99);
    chk("stream_tail", out_bus.d, 8'd99);
    drv_v = 1'b0;
    step();

    // random traffic with stalls; the producer holds a word until accepted
    drv_v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!drv_v || last_push) begin
        drv_v = 1'($urandom_range(0, 1));
        drv_d = N'($urandom_range(0, 255));
      end
      drv_a = 1'($urandom_range(0, 1));
      step();
    end
    drv_v = 1'b0;
    drv_a = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("rand_drained", empty, 1);

    // simultaneous push and pop at count = 2
    drv_a = 1'b0;
    drv_v = 1'b1;
    drv_d = 8'hA1;
    step();
    drv_d = 8'hA2;
    step();
    drv_d = 8'hA3;
    drv_a = 1'b1;
    #1;
    chk("simul_head", out_bus.d, 8'hA1);
    step();
    drv_v = 1'b0;
    drv_a = 1'b0;
    #1;
    chk("simul_count", count, 2);
    chk("simul_next",  out_bus.d, 8'hA2);

    // reset with three words buffered
    drv_v = 1'b1;
    drv_d = 8'hA4;
    step();
    #1;
    chk("pre_rst_count", count, 3);
    drv_rst = 1'b1;
    drv_d   = 8'hEE;
    step();
    drv_rst = 1'b0;
    drv_v   = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_v", out_bus.v, 0);
    drv_v = 1'b1;
    drv_d = 8'hAB;
    step();
    drv_v = 1'b0;
    drv_a = 1'b1;
    #1;
    chk("post_rst_v", out_bus.v, 1);
    chk("post_rst_d", out_bus.d, 8'hAB);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
